// File: rtl/shift_add_mult8_pkg.sv
// Shared constants for the shift-and-add multiplier.
// Holds the FSM state encodings and the fixed datapath widths.
// The adder datapath is 8 bits wide, so WIDTH is fixed at 8.
package shift_add_mult8_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/shift_add_mult8_rca.sv
// RippleCarryAdder8: 8-bit ripple-carry adder, one full-adder per bit.
// Purely combinational, so it adds no cycles of latency.
// No handshake and no backpressure: the sum follows the inputs.
module RippleCarryAdder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    // Carry ripples from bit 0 upward through eight full-adder cells.
    always_comb begin
        carry    = 9'd0;
        sum      = 8'd0;
        carry[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[8];
    end

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier with a 16-bit product.
// Latency: the result is ready 9 cycles after the accepting edge (8 steps plus DONE).
// Backpressure: start is only sampled in IDLE and is ignored while busy; nothing is queued.
module shift_add_mult8
    import shift_add_mult8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   m_reg;
    logic               c_reg;
    logic [CNT_W-1:0]   count;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    logic               c_next;
    logic [WIDTH-1:0]   a_next;
    logic [WIDTH-1:0]   q_next;

    // The adder only sees M when the current multiplier LSB is set.
    assign add_b = q_reg[0] ? m_reg : '0;

    RippleCarryAdder8 u_adder (
        .a    (a_reg),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {C,A,Q} <= {cout,S,Q} >> 1: the adder carry-out lands in the A MSB.
    always_comb begin
        c_next = 1'b0;
        a_next = {add_cout, add_sum[WIDTH-1:1]};
        q_next = {add_sum[0], q_reg[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; the illegal encoding falls back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            c_reg   <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        c_reg <= 1'b0;
                        count <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    c_reg <= c_next;
                    a_reg <= a_next;
                    q_reg <= q_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        product <= {a_next, q_next};
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_CALC) || (state == S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_add_mult8.sv
// Self-checking bench for shift_add_mult8 against a plain a*b reference.
// Checks timing of busy/done cycle by cycle relative to the accepting edge.
// Covers corners, back-to-back starts, ignored starts and async reset.
module tb_shift_add_mult8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int          n_tests;
    int          n_fail;
    logic [15:0] last_prod;

    shift_add_mult8 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bounded wait until the DUT is idle, sampled on the falling edge.
    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy === 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // One full operation with a one-cycle start pulse; cycle k lies between E(k-1) and Ek.
    task automatic do_op(input logic [7:0] m, input logic [7:0] q);
        logic [15:0] exp;
        exp = 16'(m) * 16'(q);
        wait_idle();
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            chk("op_busy", 32'(busy), 32'(cyc <= 9));
            chk("op_done", 32'(done), 32'(cyc == 9));
            chk("op_prod", 32'(product), 32'((cyc <= 8) ? last_prod : exp));
        end
        last_prod = exp;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        last_prod    = 16'd0;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = 8'd0;
        multiplier   = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_prod", 32'(product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Directed corner cases.
        do_op(8'd13, 8'd11);
        chk("p143", 32'(product), 32'd143);
        do_op(8'd255, 8'd255);
        chk("p65025", 32'(product), 32'hFE01);
        do_op(8'd0, 8'd200);
        do_op(8'd200, 8'd0);

        // Back-to-back with start held high throughout.
        wait_idle();
        start        = 1'b1;
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        @(posedge clk);
        #1;
        multiplicand = 8'd128;
        multiplier   = 8'd2;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 20) start = 1'b0;
            chk("b2b_busy", 32'(busy), 32'(cyc != 10 && cyc != 20));
            chk("b2b_done", 32'(done), 32'(cyc == 9 || cyc == 19));
            chk("b2b_prod", 32'(product),
                32'((cyc <= 8) ? last_prod : (cyc <= 18) ? 16'd63 : 16'd256));
        end
        last_prod = 16'd256;

        // Start during CALC with other operands must be ignored.
        wait_idle();
        start        = 1'b1;
        multiplicand = 8'd12;
        multiplier   = 8'd12;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 3) begin
                start        = 1'b1;
                multiplicand = 8'd3;
                multiplier   = 8'd3;
            end
            if (cyc == 6) start = 1'b0;
            chk("ign_busy", 32'(busy), 32'(cyc <= 9));
            chk("ign_done", 32'(done), 32'(cyc == 9));
            chk("ign_prod", 32'(product), 32'((cyc <= 8) ? last_prod : 16'd144));
        end
        last_prod = 16'd144;

        // Async reset in the middle of a cycle after step 4 of 100 x 100.
        wait_idle();
        start        = 1'b1;
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_prod", 32'(product), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_prod = 16'd0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            chk("arst_nodone", 32'(done), 32'd0);
        end
        do_op(8'd5, 8'd6);
        chk("p30", 32'(product), 32'd30);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst          = 1'b1;
        start        = 1'b1;
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        @(posedge clk);
        #1;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_prod", 32'(product), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rs_idle", 32'(busy), 32'd0);
        last_prod = 16'd0;

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            do_op(8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
